// File: rtl/act_feeder.sv
// Activation loader ahead of the SHIFT skew buffer: issues sequential buffer
// reads, packs SRAM words into WIDTH-lane rows, and tags the tile's last row.
module act_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 32,
    parameter int SRAM_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_WIDTH  = 16,
    parameter int MAX_OUT    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Rst,
    input  logic                        cfg_vld,
    output logic                        cfg_rdy,
    input  logic [ADDR_WIDTH-1:0]       cfg_base_addr,
    input  logic [NUM_WIDTH-1:0]        cfg_num,
    output logic [ADDR_WIDTH-1:0]       rdaddr,
    output logic                        rdaddr_vld,
    input  logic                        rdaddr_rdy,
    input  logic [SRAM_WIDTH-1:0]       rddat,
    input  logic                        rddat_vld,
    output logic                        rddat_rdy,
    output logic [WIDTH*DATA_WIDTH-1:0] feed_dout,
    output logic                        feed_dout_vld,
    output logic                        feed_dout_last,
    input  logic                        feed_dout_rdy,
    output logic                        busy
);

    localparam int ROW_W  = WIDTH * DATA_WIDTH;
    localparam int WPR    = ROW_W / SRAM_WIDTH;
    localparam int WIDX_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int CNT_W  = NUM_WIDTH + $clog2(WPR);
    localparam int OUT_W  = $clog2(MAX_OUT + 1);

    localparam logic [WIDX_W-1:0] W_LAST    = WIDX_W'(WPR - 1);
    localparam logic [CNT_W-1:0]  WPR_C     = CNT_W'(WPR);
    localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [NUM_WIDTH-1:0]   num_q, num_d;
    logic [ADDR_WIDTH-1:0]  rdaddr_q, rdaddr_d;
    logic [CNT_W-1:0]       req_cnt_q, req_cnt_d;
    logic [OUT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [WIDX_W-1:0]      w_q, w_d;
    logic [NUM_WIDTH-1:0]   row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]       dout_q, dout_d;
    logic                   dout_vld_q, dout_vld_d;
    logic                   dout_last_q, dout_last_d;
    logic [ROW_W-1:0]       pack_q;
    logic [ROW_W-1:0]       row_next;

    logic [CNT_W-1:0] total_words;
    logic             addr_hs, data_hs, pop, word_last, load;

    assign total_words = CNT_W'(num_q) * WPR_C;
    assign word_last   = (w_q == W_LAST);
    assign addr_hs     = rdaddr_vld && rdaddr_rdy;
    assign data_hs     = rddat_vld && rddat_rdy;
    assign pop         = dout_vld_q && feed_dout_rdy;
    assign load        = data_hs && word_last;

    assign cfg_rdy    = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rdaddr_vld = (state_q == RUN) && (req_cnt_q < total_words) && (out_cnt_q < MAX_OUT_C);
    // The closing word of a row waits only while the previous row is still blocked.
    assign rddat_rdy  = (state_q == RUN) && !(word_last && dout_vld_q && !feed_dout_rdy);

    assign rdaddr         = rdaddr_q;
    assign feed_dout      = dout_q;
    assign feed_dout_vld  = dout_vld_q;
    assign feed_dout_last = dout_last_q;

    always_comb begin
        // NOTE: every next-state starts from its current value so no path can infer a latch.
        state_d     = state_q;
        num_d       = num_q;
        rdaddr_d    = rdaddr_q;
        req_cnt_d   = req_cnt_q;
        out_cnt_d   = out_cnt_q;
        w_d         = w_q;
        row_cnt_d   = row_cnt_q;
        dout_d      = dout_q;
        dout_vld_d  = dout_vld_q;
        dout_last_d = dout_last_q;
        row_next    = pack_q;
        row_next[ROW_W-SRAM_WIDTH +: SRAM_WIDTH] = rddat;

        case (state_q)
            IDLE: begin
                if (cfg_vld) begin
                    num_d       = cfg_num;
                    rdaddr_d    = cfg_base_addr;
                    req_cnt_d   = '0;
                    out_cnt_d   = '0;
                    w_d         = '0;
                    row_cnt_d   = '0;
                    dout_vld_d  = 1'b0;
                    dout_last_d = 1'b0;
                    state_d     = (cfg_num == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (addr_hs) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                    rdaddr_d  = rdaddr_q + ADDR_WIDTH'(1);
                end
                if (addr_hs && !data_hs) out_cnt_d = out_cnt_q + OUT_W'(1);
                if (!addr_hs && data_hs) out_cnt_d = out_cnt_q - OUT_W'(1);
                if (data_hs) w_d = word_last ? '0 : w_q + WIDX_W'(1);
                if (pop) dout_vld_d = 1'b0;
                if (load) begin
                    dout_d      = row_next;
                    dout_vld_d  = 1'b1;
                    dout_last_d = (row_cnt_q == num_q - NUM_WIDTH'(1));
                    row_cnt_d   = row_cnt_q + NUM_WIDTH'(1);
                end
                if (pop && dout_last_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (Rst) begin
            state_d     = IDLE;
            num_d       = '0;
            rdaddr_d    = '0;
            req_cnt_d   = '0;
            out_cnt_d   = '0;
            w_d         = '0;
            row_cnt_d   = '0;
            dout_d      = '0;
            dout_vld_d  = 1'b0;
            dout_last_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            rdaddr_q    <= '0;
            req_cnt_q   <= '0;
            out_cnt_q   <= '0;
            w_q         <= '0;
            row_cnt_q   <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            rdaddr_q    <= rdaddr_d;
            req_cnt_q   <= req_cnt_d;
            out_cnt_q   <= out_cnt_d;
            w_q         <= w_d;
            row_cnt_q   <= row_cnt_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_last_q <= dout_last_d;
        end
    end

    // NOTE: the packing buffer is not reset; the word index alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (data_hs && !word_last) pack_q[w_q*SRAM_WIDTH +: SRAM_WIDTH] <= rddat;
    end

endmodule

// File: tb/tb_act_feeder.sv
// Self-checking bench for act_feeder: table of tiles driven against a
// latency-configurable buffer model, plus reset corner-case sequences.
module tb_act_feeder;

    localparam int ROW_W = 256;

    typedef struct {
        logic [15:0] base;
        logic [15:0] num;
        int          lat;
        bit          bp;
        int          stop;
        int          rows_exp;
        int          reqs_exp;
        int          span_exp;
        int          rdy_dly_exp;
    } vec_t;

    typedef struct {
        logic [ROW_W-1:0] data;
        logic             last;
    } row_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;

    logic             clk = 1'b0;
    logic             rst_n, Rst;
    logic             cfg_vld, cfg_rdy;
    logic [15:0]      cfg_base_addr, cfg_num;
    logic [15:0]      rdaddr;
    logic             rdaddr_vld, rdaddr_rdy;
    logic [127:0]     rddat;
    logic             rddat_vld, rddat_rdy;
    logic [ROW_W-1:0] feed_dout;
    logic             feed_dout_vld, feed_dout_last, feed_dout_rdy;
    logic             busy;

    int n_pass = 0;
    int n_total = 0;

    row_t        sb_rows[$];
    logic [15:0] sb_addr[$];
    rd_t         mem_q[$];
    vec_t        vecs[5];
    vec_t        tail;

    act_feeder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Rst            (Rst),
        .cfg_vld        (cfg_vld),
        .cfg_rdy        (cfg_rdy),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_num        (cfg_num),
        .rdaddr         (rdaddr),
        .rdaddr_vld     (rdaddr_vld),
        .rdaddr_rdy     (rdaddr_rdy),
        .rddat          (rddat),
        .rddat_vld      (rddat_vld),
        .rddat_rdy      (rddat_rdy),
        .feed_dout      (feed_dout),
        .feed_dout_vld  (feed_dout_vld),
        .feed_dout_last (feed_dout_last),
        .feed_dout_rdy  (feed_dout_rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] word_of(input logic [15:0] a);
        return {16{a[7:0]}};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, ".cfg_rdy"},        cfg_rdy,        1);
        check({tag, ".busy"},           busy,           0);
        check({tag, ".rdaddr_vld"},     rdaddr_vld,     0);
        check({tag, ".rdaddr"},         rdaddr,         0);
        check({tag, ".rddat_rdy"},      rddat_rdy,      0);
        check({tag, ".feed_dout_vld"},  feed_dout_vld,  0);
        check({tag, ".feed_dout_last"}, feed_dout_last, 0);
        check({tag, ".feed_dout"},      feed_dout,      0);
    endtask

    task automatic run_tile(input vec_t v, input string tag);
        int cfg_cyc = -1, first_req = -1, ev_cyc = -1, rdy_dly = -1;
        int n_req = 0, n_rows = 0, pre_data = 0, outst = 0, max_outst = 0;
        int first_pop = -1, last_pop = -1, stable_err = 0;
        bit cfg_done = 0, seen_data = 0, finished = 0, hold_vld = 0;
        logic [ROW_W-1:0] held_data;
        logic             held_last;
        row_t             er;

        sb_rows.delete();
        sb_addr.delete();
        mem_q.delete();
        held_data = '0;
        held_last = 1'b0;
        for (int k = 0; k < int'(v.num); k++) begin
            er.data = {word_of(16'(v.base + 2*k + 1)), word_of(16'(v.base + 2*k))};
            er.last = (k == int'(v.num) - 1);
            sb_rows.push_back(er);
            sb_addr.push_back(16'(v.base + 2*k));
            sb_addr.push_back(16'(v.base + 2*k + 1));
        end

        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk);
            cfg_vld       = !cfg_done;
            cfg_base_addr = v.base;
            cfg_num       = v.num;
            feed_dout_rdy = v.bp ? ((cyc / 3) % 2 == 1) : 1'b1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                rddat_vld = 1'b1;
                rddat     = word_of(mem_q[0].addr);
            end else begin
                rddat_vld = 1'b0;
                rddat     = '0;
            end
            #1;
            if (cfg_vld && cfg_rdy) begin
                cfg_done = 1;
                cfg_cyc  = cyc;
                if (v.num == 0) ev_cyc = cyc;
            end
            if (rdaddr_vld && rdaddr_rdy) begin
                if (first_req < 0) first_req = cyc;
                if (!seen_data) pre_data++;
                n_req++;
                outst++;
                if (sb_addr.size() > 0) check({tag, ".addr"}, rdaddr, sb_addr.pop_front());
                else check({tag, ".extra_req"}, n_req, v.reqs_exp);
                mem_q.push_back('{rdaddr, cyc + v.lat});
            end
            if (rddat_vld && rddat_rdy) begin
                mem_q.delete(0);
                outst--;
                seen_data = 1;
            end
            if (outst > max_outst) max_outst = outst;
            if (hold_vld && (!feed_dout_vld || feed_dout !== held_data || feed_dout_last !== held_last))
                stable_err++;
            hold_vld  = feed_dout_vld && !feed_dout_rdy;
            held_data = feed_dout;
            held_last = feed_dout_last;
            if (feed_dout_vld && feed_dout_rdy) begin
                n_rows++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                if (sb_rows.size() > 0) begin
                    er = sb_rows.pop_front();
                    check({tag, ".row_data"}, feed_dout, er.data);
                    check({tag, ".row_last"}, feed_dout_last, er.last);
                end else begin
                    check({tag, ".extra_row"}, n_rows, v.rows_exp);
                end
                if (feed_dout_last) ev_cyc = cyc;
                if (v.stop > 0 && n_rows == v.stop) finished = 1;
            end
            if (ev_cyc >= 0 && cyc > ev_cyc && cfg_rdy && !finished) begin
                rdy_dly  = cyc - ev_cyc;
                finished = 1;
            end
        end

        cfg_vld   = 1'b0;
        rddat_vld = 1'b0;
        rddat     = '0;
        check({tag, ".completed"}, finished, 1);
        if (v.stop == 0) begin
            check({tag, ".rows"},       n_rows,          v.rows_exp);
            check({tag, ".reqs"},       n_req,           v.reqs_exp);
            check({tag, ".cfg_rdy_dly"}, rdy_dly,        v.rdy_dly_exp);
            check({tag, ".stable"},     stable_err,      0);
            check({tag, ".max_outst"},  max_outst <= 4,  1);
            check({tag, ".pre_data"},   pre_data <= 4,   1);
            if (v.num != 0) check({tag, ".first_req_lat"}, first_req - cfg_cyc, 1);
            if (v.span_exp >= 0) check({tag, ".row_span"}, last_pop - first_pop, v.span_exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        Rst           = 1'b0;
        cfg_vld       = 1'b0;
        cfg_base_addr = '0;
        cfg_num       = '0;
        rdaddr_rdy    = 1'b1;
        rddat         = '0;
        rddat_vld     = 1'b0;
        feed_dout_rdy = 1'b0;

        //            base      num    lat bp stop rows reqs span dly
        vecs[0] = '{16'h0100, 16'd3, 1, 1'b0, 0, 3, 6,  4,  2};
        vecs[1] = '{16'h0200, 16'd4, 1, 1'b1, 0, 4, 8,  -1, 2};
        vecs[2] = '{16'h0300, 16'd3, 6, 1'b0, 0, 3, 6,  -1, 2};
        vecs[3] = '{16'h0400, 16'd0, 1, 1'b0, 0, 0, 0,  -1, 2};
        vecs[4] = '{16'hFFFF, 16'd1, 1, 1'b0, 0, 1, 2,  0,  2};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_vals("por");

        for (int i = 0; i < 5; i++) run_tile(vecs[i], $sformatf("v%0d", i));

        // Synchronous clear mid-tile.
        run_tile('{16'h0600, 16'd3, 1, 1'b0, 1, 3, 6, -1, 2}, "rst_sync_pre");
        @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals("rst_sync");
        Rst = 1'b0;
        mem_q.delete();

        // Asynchronous reset right after row 1 of a five-row tile.
        run_tile('{16'h0500, 16'd5, 1, 1'b0, 2, 5, 10, -1, 2}, "rst_async_pre");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        mem_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        tail = '{16'h0700, 16'd1, 1, 1'b0, 0, 1, 2, 0, 2};
        run_tile(tail, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
